// File: rtl/pixel_plot_sink_pkg.sv
// Shared definitions for the pixel-plot interface: screen geometry, widths and
// the pixel-to-framebuffer address mapping used by the drawers and the sink.
package pixel_plot_sink_pkg;

    localparam int H_RES      = 320;
    localparam int V_RES      = 240;
    localparam int COLOR_W    = 3;
    localparam int ADDR_W     = 17;
    localparam int X_W        = 9;
    localparam int Y_W        = 8;
    localparam int FIFO_DEPTH = 4;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_WRITE = 1'b1
    } wr_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0]  addr;
        logic [COLOR_W-1:0] color;
    } pixel_t;

    // Y*320 + X built from two shifts so no multiplier is inferred.
    function automatic logic [ADDR_W-1:0] pixel_addr(input logic [X_W-1:0] x,
                                                     input logic [Y_W-1:0] y);
        logic [ADDR_W-1:0] yw;
        logic [ADDR_W-1:0] xw;
        yw = ADDR_W'(y);
        xw = ADDR_W'(x);
        return (yw << 8) + (yw << 6) + xw;
    endfunction

    function automatic logic pixel_in_range(input logic [X_W-1:0] x,
                                            input logic [Y_W-1:0] y);
        return (x < X_W'(H_RES)) && (y < Y_W'(V_RES));
    endfunction

endpackage

// File: rtl/pixel_plot_sink_fifo.sv
// Small synchronous FIFO for buffered pixels. A push into a full FIFO is
// accepted only when a pop frees the head slot in the same cycle.
module pixel_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 20
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] rdata
);

    localparam int PW = $clog2(DEPTH);

    // The extra MSB on each pointer separates full from empty.
    logic [PW:0]      wr_ptr_q, wr_ptr_d;
    logic [PW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    always_comb begin
        full     = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                   (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
        empty    = (wr_ptr_q == rd_ptr_q);
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q + (PW+1)'(do_push);
        rd_ptr_d = rd_ptr_q + (PW+1)'(do_pop);
        rdata    = mem_q[rd_ptr_q[PW-1:0]];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q[PW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/pixel_plot_sink.sv
// Pixel-plot sink: range-checks and linearises plotted pixels, buffers them,
// and writes them to the framebuffer port under a ready handshake.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | write stage empty, mem_we low
//   S_WRITE | mem_we high, address/data held until mem_ready
module pixel_plot_sink
    import pixel_plot_sink_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               plot,
    input  logic [X_W-1:0]     X,
    input  logic [Y_W-1:0]     Y,
    input  logic [COLOR_W-1:0] color,
    input  logic               clear,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [COLOR_W-1:0] mem_data,
    input  logic               mem_ready,
    output logic               idle,
    output logic [ADDR_W-1:0]  pixel_count,
    output logic               overflow,
    output logic               oob
);

    logic                     s1_valid_q, s1_valid_d;
    pixel_t                   s1_pix_q, s1_pix_d;
    wr_state_e                state_q, state_d;
    pixel_t                   wr_pix_q, wr_pix_d;
    logic [ADDR_W-1:0]        count_q, count_d;
    logic                     ovf_q, ovf_d;
    logic                     oob_q, oob_d;
    logic                     idle_q, idle_d;

    logic                     fifo_push;
    logic                     fifo_pop;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic [$bits(pixel_t)-1:0] fifo_rdata;
    pixel_t                   fifo_head;

    logic                     in_rng;
    logic                     plot_oob;
    logic                     load_ok;
    logic                     bypass;
    logic                     write_done;
    logic                     drop_full;

    pixel_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(pixel_t))
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (s1_pix_q),
        .full  (fifo_full),
        .empty (fifo_empty),
        .rdata (fifo_rdata)
    );

    assign fifo_head = pixel_t'(fifo_rdata);

    always_comb begin
        in_rng         = pixel_in_range(X, Y);
        plot_oob       = plot && !in_rng;
        s1_valid_d     = plot && in_rng;
        s1_pix_d.addr  = pixel_addr(X, Y);
        s1_pix_d.color = color;

        write_done = (state_q == S_WRITE) && mem_ready;
        load_ok    = (state_q == S_IDLE) || mem_ready;
        fifo_pop   = load_ok && !fifo_empty;
        // An empty FIFO is skipped so a lone pixel reaches the port two cycles after plot.
        bypass     = load_ok && fifo_empty && s1_valid_q;
        fifo_push  = s1_valid_q && !bypass && (!fifo_full || fifo_pop);
        drop_full  = s1_valid_q && !bypass && fifo_full && !fifo_pop;

        state_d  = state_q;
        wr_pix_d = wr_pix_q;
        if (load_ok) begin
            if (fifo_pop) begin
                wr_pix_d = fifo_head;
                state_d  = S_WRITE;
            end else if (bypass) begin
                wr_pix_d = s1_pix_q;
                state_d  = S_WRITE;
            end else begin
                state_d  = S_IDLE;
            end
        end

        if (clear) begin
            count_d = '0;
        end else if (write_done && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end else begin
            count_d = count_q;
        end

        ovf_d  = !clear && (ovf_q || drop_full);
        oob_d  = !clear && (oob_q || plot_oob);
        // Reaching S_IDLE implies the FIFO had nothing to offer this cycle.
        idle_d = !s1_valid_d && fifo_empty && (state_d == S_IDLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_pix_q   <= '0;
            state_q    <= S_IDLE;
            wr_pix_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            oob_q      <= 1'b0;
            idle_q     <= 1'b1;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_pix_q   <= s1_pix_d;
            state_q    <= state_d;
            wr_pix_q   <= wr_pix_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            oob_q      <= oob_d;
            idle_q     <= idle_d;
        end
    end

    assign mem_we      = (state_q == S_WRITE);
    assign mem_addr    = wr_pix_q.addr;
    assign mem_data    = wr_pix_q.color;
    assign idle        = idle_q;
    assign pixel_count = count_q;
    assign overflow    = ovf_q;
    assign oob         = oob_q;

endmodule

// File: tb/tb_pixel_plot_sink.sv
// Scoreboard bench for pixel_plot_sink: stimulus pushes expected writes,
// a negedge monitor compares every framebuffer write against the queue head.
module tb_pixel_plot_sink;
    import pixel_plot_sink_pkg::*;

    logic               clock = 1'b0;
    logic               reset;
    logic               plot;
    logic [X_W-1:0]     X;
    logic [Y_W-1:0]     Y;
    logic [COLOR_W-1:0] color;
    logic               clear;
    logic               mem_we;
    logic [ADDR_W-1:0]  mem_addr;
    logic [COLOR_W-1:0] mem_data;
    logic               mem_ready;
    logic               idle;
    logic [ADDR_W-1:0]  pixel_count;
    logic               overflow;
    logic               oob;

    logic ready_ctl;
    logic rnd_ready;
    logic rand_mode;

    typedef struct {
        int addr;
        int data;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   errors   = 0;
    int   wr_count = 0;

    assign mem_ready = rand_mode ? rnd_ready : ready_ctl;

    pixel_plot_sink dut (
        .clock       (clock),
        .reset       (reset),
        .plot        (plot),
        .X           (X),
        .Y           (Y),
        .color       (color),
        .clear       (clear),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .mem_ready   (mem_ready),
        .idle        (idle),
        .pixel_count (pixel_count),
        .overflow    (overflow),
        .oob         (oob)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_exp(input int x, input int y, input int c);
        exp_t e;
        e.addr = y * 320 + x;
        e.data = c;
        exp_q.push_back(e);
    endtask

    task automatic plot_px(input int x, input int y, input int c);
        X     = X_W'(x);
        Y     = Y_W'(y);
        color = COLOR_W'(c);
        plot  = 1'b1;
        if (x < 320 && y < 240) push_exp(x, y, c);
        tick();
        plot = 1'b0;
    endtask

    task automatic wait_we(input int budget);
        int n;
        n = 0;
        while (!mem_we && n < budget) begin
            tick();
            n++;
        end
        check("wait_we_timeout", 32'(mem_we), 32'd1);
    endtask

    // Monitor: every presented write must match the head; it is retired on mem_ready.
    always @(negedge clock) begin
        if (!reset && mem_we) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %0d data %0d expected none (t=%0t)",
                         mem_addr, mem_data, $time);
            end else begin
                check("wr_addr", 32'(mem_addr), exp_q[0].addr);
                check("wr_data", 32'(mem_data), exp_q[0].data);
                if (mem_ready) begin
                    void'(exp_q.pop_front());
                    wr_count++;
                end
            end
        end
    end

    // Random 0-2 cycle mem_ready stalls for the raster run.
    initial begin
        int stall_left;
        stall_left = 0;
        rnd_ready  = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            if (stall_left > 0) begin
                rnd_ready = 1'b0;
                stall_left--;
            end else begin
                rnd_ready  = 1'b1;
                stall_left = int'($urandom_range(0, 2));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int n;
        reset = 1'b1; plot = 1'b0; X = '0; Y = '0; color = '0; clear = 1'b0;
        ready_ctl = 1'b1; rand_mode = 1'b0;
        #12;
        check("rst_we", 32'(mem_we), 0);
        check("rst_addr", 32'(mem_addr), 0);
        check("rst_data", 32'(mem_data), 0);
        check("rst_idle", 32'(idle), 1);
        check("rst_count", 32'(pixel_count), 0);
        check("rst_ovf", 32'(overflow), 0);
        check("rst_oob", 32'(oob), 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        tick();

        // Single pixel, latency and idle
        X = 9'd5; Y = 8'd2; color = 3'b101; plot = 1'b1;
        push_exp(5, 2, 5);
        tick();
        plot = 1'b0;
        check("t1_we_early", 32'(mem_we), 0);
        check("t1_idle_busy", 32'(idle), 0);
        tick();
        check("t1_we", 32'(mem_we), 1);
        check("t1_addr", 32'(mem_addr), 645);
        check("t1_data", 32'(mem_data), 5);
        tick();
        check("t1_we_done", 32'(mem_we), 0);
        check("t1_count", 32'(pixel_count), 1);
        check("t1_idle", 32'(idle), 1);

        // Range corners
        plot_px(319, 239, 7);
        repeat (4) tick();
        check("t2_count", 32'(pixel_count), 2);
        check("t2_oob_clean", 32'(oob), 0);
        plot_px(320, 0, 1);
        plot_px(0, 240, 2);
        repeat (4) tick();
        check("t2_oob", 32'(oob), 1);
        check("t2_count_hold", 32'(pixel_count), 2);
        check("t2_idle", 32'(idle), 1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("t2_clr_oob", 32'(oob), 0);
        check("t2_clr_count", 32'(pixel_count), 0);

        // Stall with three pending pixels (includes a duplicate address)
        ready_ctl = 1'b0;
        plot_px(10, 0, 1);
        tick();
        plot_px(20, 5, 2);
        tick();
        plot_px(20, 5, 2);
        repeat (4) tick();
        check("t3_we_held", 32'(mem_we), 1);
        check("t3_addr_held", 32'(mem_addr), 10);
        base = wr_count;
        ready_ctl = 1'b1;
        repeat (3) tick();
        check("t3_writes", wr_count - base, 3);
        check("t3_we_off", 32'(mem_we), 0);
        check("t3_count", 32'(pixel_count), 3);

        // Overflow: six back-to-back plots into a stalled sink
        ready_ctl = 1'b0;
        for (int i = 0; i < 6; i++) begin
            X = X_W'(i); Y = 8'd3; color = COLOR_W'(i); plot = 1'b1;
            if (i < 5) push_exp(i, 3, i);
            tick();
        end
        plot = 1'b0;
        repeat (2) tick();
        check("t4_ovf", 32'(overflow), 1);
        base = wr_count;
        ready_ctl = 1'b1;
        repeat (10) tick();
        check("t4_writes", wr_count - base, 5);
        check("t4_q_empty", exp_q.size(), 0);
        check("t4_count", 32'(pixel_count), 8);
        check("t4_idle", 32'(idle), 1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("t4_clr_ovf", 32'(overflow), 0);
        check("t4_clr_count", 32'(pixel_count), 0);

        // Raster window at 1 pixel / 3 clocks with random stalls
        rand_mode = 1'b1;
        for (int y = 236; y < 240; y++) begin
            for (int x = 0; x < 320; x++) begin
                plot_px(x, y, (x ^ y) & 7);
                tick();
                tick();
            end
        end
        n = 0;
        while ((exp_q.size() != 0 || !idle) && n < 50) begin
            tick();
            n++;
        end
        rand_mode = 1'b0;
        check("t5_drain", exp_q.size(), 0);
        check("t5_count", 32'(pixel_count), 1280);
        check("t5_ovf", 32'(overflow), 0);

        // Reset during a stalled write discards everything
        ready_ctl = 1'b0;
        plot_px(7, 7, 1);
        plot_px(8, 7, 2);
        wait_we(10);
        #2;
        reset = 1'b1;
        #1;
        check("t6_rst_we", 32'(mem_we), 0);
        check("t6_rst_idle", 32'(idle), 1);
        check("t6_rst_count", 32'(pixel_count), 0);
        exp_q.delete();
        ready_ctl = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        base = wr_count;
        repeat (5) tick();
        check("t6_no_writes", wr_count - base, 0);
        check("t6_we_off", 32'(mem_we), 0);

        // Clear coincident with a counted write
        plot_px(9, 9, 3);
        repeat (4) tick();
        check("t6_count1", 32'(pixel_count), 1);
        ready_ctl = 1'b0;
        plot_px(10, 9, 4);
        wait_we(10);
        repeat (2) tick();
        clear = 1'b1;
        ready_ctl = 1'b1;
        tick();
        clear = 1'b0;
        check("t6_clr_win", 32'(pixel_count), 0);
        check("t6_clr_we", 32'(mem_we), 0);
        check("t6_clr_q", exp_q.size(), 0);

        repeat (2) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
